// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs four bytes (LSB first) into a 32-bit command word.
// Partial words are dropped on a framing error or after an idle timeout.
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 20 * 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] data,
    output logic        valid,
    output logic        frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          r_rxMeta;
    logic          r_rxSync;
    logic [CW-1:0] r_clkCnt;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;
    logic [1:0]    r_byteIdx;
    logic [31:0]   r_asm;
    logic [31:0]   r_data;
    logic          r_valid;
    logic          r_frameErr;
    logic [TW-1:0] r_idleCnt;

    logic          w_cntClear;
    logic          w_sampleBit;
    logic          w_acceptByte;
    logic          w_stopBad;
    logic          w_idleRun;
    logic          w_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_cntClear   = 1'b0;
        w_sampleBit  = 1'b0;
        w_acceptByte = 1'b0;
        w_stopBad    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cntClear = 1'b1;
                if (!r_rxSync) begin
                    w_nextState = START;
                end
            end
            START: begin
                if (r_clkCnt == HALF_LAST) begin
                    w_cntClear  = 1'b1;
                    w_nextState = r_rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_clkCnt == BIT_LAST) begin
                    w_cntClear  = 1'b1;
                    w_sampleBit = 1'b1;
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = STOP;
                    end
                end
            end
            STOP: begin
                if (r_clkCnt == BIT_LAST) begin
                    w_cntClear = 1'b1;
                    if (r_rxSync) begin
                        w_acceptByte = 1'b1;
                        w_nextState  = IDLE;
                    end else begin
                        w_stopBad   = 1'b1;
                        w_nextState = BREAK;
                    end
                end
            end
            BREAK: begin
                w_cntClear = 1'b1;
                if (r_rxSync) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_cntClear  = 1'b1;
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clkCnt <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
        end else begin
            r_clkCnt <= w_cntClear ? '0 : r_clkCnt + CW'(1);
            if (w_sampleBit) begin
                r_bitIdx <= r_bitIdx + 3'd1;
                r_shift  <= {r_rxSync, r_shift[7:1]};
            end else if (r_state != DATA) begin
                r_bitIdx <= '0;
            end
        end
    end

    // A start edge on the expiry cycle wins, so the partial word survives.
    assign w_idleRun = (r_state == IDLE) && (r_byteIdx != 2'd0) && r_rxSync;
    assign w_timeout = w_idleRun && (r_idleCnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idleCnt <= '0;
        end else if (w_idleRun && !w_timeout) begin
            r_idleCnt <= r_idleCnt + TW'(1);
        end else begin
            r_idleCnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byteIdx  <= '0;
            r_asm      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_valid    <= w_acceptByte && (r_byteIdx == 2'd3);
            r_frameErr <= w_stopBad;
            if (w_acceptByte) begin
                r_asm[8*r_byteIdx +: 8] <= r_shift;
                r_byteIdx               <= r_byteIdx + 2'd1;
                if (r_byteIdx == 2'd3) begin
                    r_data <= {r_shift, r_asm[23:0]};
                end
            end else if (w_stopBad || w_timeout) begin
                r_byteIdx <= '0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frameErr;

endmodule
